// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state encoding, byte-strobe constants and access decode helpers.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_BYTE    = 4'b0001;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Exactly one of read/write, a known size, natural alignment, and
    // unsigned sizes only on loads.
    function automatic logic access_legal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lo[0];
            F3_W:    ok = (lo == 2'b00);
            F3_BU:   ok = rd;
            F3_HU:   ok = rd & ~lo[0];
            default: ok = 1'b0;
        endcase
        return (rd ^ wr) & ok;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B:    return STRB_BYTE << lo;
            F3_H:    return lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
            default: return STRB_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if;
    // req is held with addr/we/wdata/wstrb stable until the cycle ready=1
    // (accept); load data returns on rvalid, possibly in that same cycle.
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, wstrb, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load lane select and sign/zero extension of a returned memory word.
module lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [4:0]  sh_amt;

    always_comb begin
        sh_amt  = {addr_lo_i, 3'b000};
        shifted = rdata_i >> sh_amt;
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data_o = {24'h0, shifted[7:0]};
            F3_HU:   data_o = {16'h0, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a ready/rvalid data-memory port and
// stalls the front of the pipeline until the access completes.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_memRead,
    input  logic            mem_memWrite,
    input  logic [31:0]     mem_ALUResult,
    input  logic [31:0]     mem_readData2,
    input  logic [2:0]      mem_funct3,
    mem_stage_lsu_if.master dmem,
    output logic            lsu_stall,
    output logic [31:0]     lsu_loadData,
    output logic            lsu_fault,
    output lsu_state_e      state_o
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] load_q;
    logic [31:0] load_d;
    logic        any_req;
    logic        legal;

    assign any_req = mem_memRead | mem_memWrite;
    assign legal   = access_legal(mem_memRead, mem_memWrite, mem_funct3, mem_ALUResult[1:0]);

    lsu_load_align u_align (
        .rdata_i   (dmem.rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (load_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= STRB_NONE;
            funct3_q <= '0;
            we_q     <= 1'b0;
            load_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (legal) begin
                        addr_q   <= mem_ALUResult;
                        wdata_q  <= mem_memWrite ? store_wdata(mem_funct3, mem_readData2) : '0;
                        wstrb_q  <= mem_memWrite ? store_strobe(mem_funct3, mem_ALUResult[1:0])
                                                 : STRB_NONE;
                        funct3_q <= mem_funct3;
                        we_q     <= mem_memWrite;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A zero-latency memory may return rvalid with ready.
                    if (dmem.ready) begin
                        if (we_q) begin
                            state_q <= S_DONE;
                        end else if (dmem.rvalid) begin
                            load_q  <= load_d;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (dmem.rvalid) begin
                        load_q  <= load_d;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem.req   = (state_q == S_REQ);
    assign dmem.we    = (state_q == S_REQ) & we_q;
    assign dmem.addr  = {addr_q[31:2], 2'b00};
    assign dmem.wdata = wdata_q;
    assign dmem.wstrb = (state_q == S_REQ) ? wstrb_q : STRB_NONE;

    // The IDLE term covers the cycle the access is first seen, before REQ.
    assign lsu_stall    = rst & (((state_q == S_IDLE) & legal) |
                                 (state_q == S_REQ) | (state_q == S_RESP));
    assign lsu_fault    = rst & (state_q == S_IDLE) & any_req & ~legal;
    assign lsu_loadData = load_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu with a scripted memory slave.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [31:0] mem_ALUResult;
    logic [31:0] mem_readData2;
    logic [2:0]  mem_funct3;
    logic        lsu_stall;
    logic [31:0] lsu_loadData;
    logic        lsu_fault;
    lsu_state_e  state_o;

    mem_stage_lsu_if dmem_if ();

    mem_stage_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_ALUResult (mem_ALUResult),
        .mem_readData2 (mem_readData2),
        .mem_funct3    (mem_funct3),
        .dmem          (dmem_if),
        .lsu_stall     (lsu_stall),
        .lsu_loadData  (lsu_loadData),
        .lsu_fault     (lsu_fault),
        .state_o       (state_o)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_ld_reg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, act, exp);
        end
    endtask

    function automatic logic exp_legal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
        if (rd == wr) return 1'b0;
        case (f3)
            3'b000:  return 1'b1;
            3'b001:  return lo[0] == 1'b0;
            3'b010:  return lo == 2'b00;
            3'b100:  return rd;
            3'b101:  return rd && (lo[0] == 1'b0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] exp_strobe(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
        if (!wr) return 4'b0000;
        case (f3)
            3'b000: case (lo)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
            3'b001:  return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'b001:  return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] r, input logic [1:0] lo, input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0: b = r[7:0];
            2'd1: b = r[15:8];
            2'd2: b = r[23:16];
            default: b = r[31:24];
        endcase
        h = lo[1] ? r[31:16] : r[15:0];
        case (f3)
            3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
            3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return r;
        endcase
    endfunction

    task automatic drive_inputs(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f3);
        mem_memRead   = rd;
        mem_memWrite  = wr;
        mem_ALUResult = a;
        mem_readData2 = d;
        mem_funct3    = f3;
    endtask

    // Called between a negedge and the following posedge.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                              input int ready_wait, input int rv_wait, input logic [31:0] rdata);
        logic        legal;
        int          stall_cnt;
        int          req_cnt;
        int          resp_cnt;
        bit          done;
        logic [31:0] exp_ld;
        legal = exp_legal(rd, wr, f3, a[1:0]);
        if (legal && rd) exp_q.push_back(exp_load(rdata, a[1:0], f3));
        drive_inputs(rd, wr, a, d, f3);
        if (!legal) begin
            #1;
            check($sformatf("%s.fault", tag), 32'(lsu_fault), 32'd1);
            check($sformatf("%s.nostall", tag), 32'(lsu_stall), 32'd0);
            check($sformatf("%s.noreq", tag), 32'(dmem_if.req), 32'd0);
            @(negedge clk);
            drive_inputs(1'b0, 1'b0, '0, '0, '0);
            #1;
            check($sformatf("%s.fault_gone", tag), 32'(lsu_fault), 32'd0);
            check($sformatf("%s.idle", tag), 32'(state_o), 32'(S_IDLE));
            return;
        end
        stall_cnt = 0;
        req_cnt   = 0;
        resp_cnt  = 0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            #1;
            dmem_if.ready  = 1'b0;
            dmem_if.rvalid = 1'b0;
            dmem_if.rdata  = $urandom;
            if (lsu_stall) stall_cnt++;
            if (state_o == S_DONE) begin
                done = 1'b1;
                check($sformatf("%s.done_stall", tag), 32'(lsu_stall), 32'd0);
                check($sformatf("%s.done_req", tag), 32'(dmem_if.req), 32'd0);
                if (rd) begin
                    exp_ld = exp_q.pop_front();
                    exp_ld_reg = exp_ld;
                end
                check($sformatf("%s.loaddata", tag), lsu_loadData, exp_ld_reg);
                drive_inputs(1'b0, 1'b0, '0, '0, '0);
            end else if (dmem_if.req) begin
                req_cnt++;
                check($sformatf("%s.addr", tag), dmem_if.addr, {a[31:2], 2'b00});
                check($sformatf("%s.we", tag), 32'(dmem_if.we), 32'(wr));
                check($sformatf("%s.wstrb", tag), 32'(dmem_if.wstrb), 32'(exp_strobe(wr, f3, a[1:0])));
                if (wr) check($sformatf("%s.wdata", tag), dmem_if.wdata, exp_wdata(f3, d));
                if (req_cnt == ready_wait + 1) begin
                    dmem_if.ready = 1'b1;
                    if (rd && rv_wait == 0) begin
                        dmem_if.rvalid = 1'b1;
                        dmem_if.rdata  = rdata;
                    end
                end
            end else if (state_o == S_RESP) begin
                resp_cnt++;
                if (resp_cnt == rv_wait) begin
                    dmem_if.rvalid = 1'b1;
                    dmem_if.rdata  = rdata;
                end
            end
            @(negedge clk);
        end
        if (!done) begin
            check($sformatf("%s.timeout", tag), 32'd0, 32'd1);
            drive_inputs(1'b0, 1'b0, '0, '0, '0);
            dmem_if.ready  = 1'b0;
            dmem_if.rvalid = 1'b0;
        end
        check($sformatf("%s.stall_cycles", tag), 32'(stall_cnt),
              32'(1 + ready_wait + 1 + (rd ? rv_wait : 0)));
        // Idle cycle with a stray rvalid that must not touch the load register.
        #1;
        check($sformatf("%s.idle_req", tag), 32'(dmem_if.req), 32'd0);
        check($sformatf("%s.idle_we", tag), 32'(dmem_if.we), 32'd0);
        check($sformatf("%s.idle_wstrb", tag), 32'(dmem_if.wstrb), 32'd0);
        check($sformatf("%s.idle_stall", tag), 32'(lsu_stall), 32'd0);
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = $urandom;
        @(negedge clk);
        #1;
        dmem_if.rvalid = 1'b0;
        check($sformatf("%s.stray_rvalid", tag), lsu_loadData, exp_ld_reg);
        check($sformatf("%s.stray_state", tag), 32'(state_o), 32'(S_IDLE));
    endtask

    task automatic reset_in_resp();
        exp_q.push_back(32'h0);
        drive_inputs(1'b1, 1'b0, 32'h500, '0, F3_W);
        @(negedge clk);
        #1;
        check("rst_resp.req", 32'(dmem_if.req), 32'd1);
        dmem_if.ready = 1'b1;
        @(negedge clk);
        #1;
        dmem_if.ready = 1'b0;
        check("rst_resp.in_resp", 32'(state_o), 32'(S_RESP));
        rst = 1'b0;
        drive_inputs(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        #1;
        check("rst_resp.idle", 32'(state_o), 32'(S_IDLE));
        check("rst_resp.stall", 32'(lsu_stall), 32'd0);
        rst = 1'b1;
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'h5A5A_1234;
        @(negedge clk);
        #1;
        dmem_if.rvalid = 1'b0;
        check("rst_resp.no_done", 32'(state_o), 32'(S_IDLE));
        check("rst_resp.stall2", 32'(lsu_stall), 32'd0);
        exp_ld_reg = exp_q.pop_front();
        check("rst_resp.loaddata", lsu_loadData, exp_ld_reg);
    endtask

    initial begin
        logic [2:0]  f3_tab [8];
        logic        rd_tab [8];
        int          op;
        logic [31:0] a;
        f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, F3_B, F3_H, F3_W};
        rd_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_ld_reg     = '0;
        rst            = 1'b0;
        dmem_if.ready  = 1'b0;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = '0;
        drive_inputs(1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        check("reset.state", 32'(state_o), 32'(S_IDLE));
        check("reset.req", 32'(dmem_if.req), 32'd0);
        check("reset.stall", 32'(lsu_stall), 32'd0);
        check("reset.fault", 32'(lsu_fault), 32'd0);
        check("reset.loaddata", lsu_loadData, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        run_access("sw_100", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, F3_W, 0, 0, '0);
        run_access("lb_203", 1'b1, 1'b0, 32'h203, '0, F3_B, 0, 1, 32'h80FF_0000);
        run_access("lbu_203", 1'b1, 1'b0, 32'h203, '0, F3_BU, 0, 0, 32'h80FF_0000);
        run_access("sh_302", 1'b0, 1'b1, 32'h302, 32'h1234ABCD, F3_H, 0, 0, '0);
        run_access("sb_101", 1'b0, 1'b1, 32'h101, 32'h0000_00A5, F3_B, 1, 0, '0);
        run_access("lw_401", 1'b1, 1'b0, 32'h401, '0, F3_W, 0, 0, '0);
        run_access("lw_wait", 1'b1, 1'b0, 32'h400, '0, F3_W, 3, 2, 32'hCAFE_F00D);
        run_access("lh_302", 1'b1, 1'b0, 32'h302, '0, F3_H, 1, 1, 32'h9ABC_0000);
        run_access("sh_odd", 1'b0, 1'b1, 32'h301, 32'h1, F3_H, 0, 0, '0);
        run_access("rd_wr", 1'b1, 1'b1, 32'h100, 32'h1, F3_W, 0, 0, '0);
        run_access("f3_011", 1'b1, 1'b0, 32'h100, '0, 3'b011, 0, 0, '0);
        run_access("sbu", 1'b0, 1'b1, 32'h100, 32'h1, F3_BU, 0, 0, '0);
        reset_in_resp();

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 7);
            a  = {20'h0, 12'($urandom)};
            if ($urandom_range(0, 5) != 0) begin
                if (f3_tab[op] == F3_W) a[1:0] = 2'b00;
                else if (f3_tab[op] != F3_B && f3_tab[op] != F3_BU) a[0] = 1'b0;
            end
            run_access($sformatf("rnd%0d", i), rd_tab[op], ~rd_tab[op], a, $urandom,
                       f3_tab[op], $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous, active-low reset.
REQ-002 SHALL have ports: mem_memRead, mem_memWrite  in  1 each  load/store request from the EX/MEM register.
REQ-003 SHALL have ports: mem_ALUResult  in  32  byte address; mem_readData2  in  32  store data; mem_funct3  in  3  access size/sign.
REQ-004 SHALL have ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32  word-aligned as {addr[31:2],2'b00}; dmem_wdata  out  32; dmem_wstrb  out  4.
REQ-005 SHALL have ports: dmem_ready  in  1  request accepted; dmem_rvalid  in  1  read data valid; dmem_rdata  in  32.
REQ-006 SHALL have ports: lsu_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; lsu_loadData  out  32  extended load result; lsu_fault  out  1  one-cycle misaligned/illegal-access pulse.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-008 IDLE: access = memRead XOR memWrite; if access and legal -> REQ; else stay IDLE.
REQ-009 lsu_stall SHALL be combinational: 1 when (IDLE and legal access) or state in {REQ, RESP}; 0 in DONE.
REQ-010 REQ: dmem_req=1, address/data/strobes registered on IDLE->REQ and held stable until dmem_ready; on dmem_ready store -> DONE, load -> RESP.
REQ-011 RESP: dmem_req=0; on dmem_rvalid capture dmem_rdata -> DONE; dmem_rvalid in the same cycle as dmem_ready SHALL be captured in REQ, going directly to DONE.
REQ-012 DONE: lsu_stall=0, lsu_loadData valid for exactly this cycle, unconditional -> IDLE.
REQ-013 Minimum latency: store 2 stall cycles (IDLE, REQ); load 3 stall cycles (IDLE, REQ, RESP), 2 when rvalid coincides with ready.
REQ-014 funct3 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned (loads only); lsu_loadData lane selected by addr[1:0], then sign/zero extended to 32 bits.
REQ-015 Store: SB wstrb=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH wstrb=0011 (addr[1]=0) or 1100, wdata={2{rs2[15:0]}}; SW wstrb=1111, wdata=rs2.
REQ-016 Illegal: half with addr[0]=1, word with addr[1:0]!=0, funct3 011/110/111, funct3 100/101 on store, memRead and memWrite both 1 -> lsu_fault=1 one cycle in IDLE, no dmem_req, no stall.
REQ-017 No access: dmem_req=0, dmem_we=0, dmem_wstrb=0, lsu_stall=0.
REQ-018 dmem_we SHALL equal 1 only in REQ for stores; dmem_wstrb SHALL be 0 for loads.
REQ-019 dmem_rvalid outside REQ/RESP SHALL be ignored.

Reset
REQ-020 rst=0 at a clock edge SHALL force IDLE and clear address, data, strobe and load-data registers to 0; dmem_req/dmem_we/lsu_fault/lsu_stall SHALL be 0 from the next cycle.
REQ-021 Reset mid-REQ or mid-RESP SHALL abandon the access; a late dmem_rvalid after reset SHALL be ignored.

Structure
REQ-022 Shared package: funct3 load/store encodings, FSM state encoding, strobe constants.
REQ-023 One sub-module lsu_load_align: combinational lane select plus sign/zero extension from (rdata, addr[1:0], funct3).

Verification
REQ-024 SW addr 0x100 data 0xDEADBEEF, ready immediate -> wstrb 1111, dmem_addr 0x100, stall 2 cycles, then DONE.
REQ-025 LB addr 0x203, rdata 0x80FF_0000 -> lsu_loadData 0xFFFFFF80; LBU same -> 0x00000080.
REQ-026 SH addr 0x302 data 0x1234ABCD -> wstrb 1100, wdata 0xABCDABCD.
REQ-027 LW addr 0x401 -> lsu_fault 1 cycle, dmem_req never 1, lsu_stall 0.
REQ-028 LW with dmem_ready after 3 wait cycles and rvalid 2 cycles later -> addr/wdata stable throughout REQ, stall held until DONE, loadData equals rdata.
REQ-029 rst=0 during RESP, then rvalid -> IDLE, no DONE, loadData 0, stall 0.
